// File: rtl/bram_seq_ctrl.sv
// Sequencing controller for a true dual-port BRAM: fills N words through port 0
// from a valid/ready stream, then reads them back in order through port 1.
module bram_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 4095,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] num_i,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic                  en0,
  output logic                  we0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] d0,
  output logic                  en1,
  output logic                  we1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] q1
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_W = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_cnt, rd_cnt;
  logic [ADDR_WIDTH:0]   n_lat, n_last, n_req;
  logic                  rd_pend;
  logic                  wr_acc, rd_iss;

  // Word count is saturated at the BRAM depth so addresses stay in range.
  function automatic logic [ADDR_WIDTH:0] clamp_n(input logic [ADDR_WIDTH-1:0] n);
    logic [ADDR_WIDTH:0] nw;
    nw = {1'b0, n};
    return (nw > MEM_W) ? MEM_W : nw;
  endfunction

  assign n_req  = clamp_n(num_i);
  assign n_last = n_lat - ONE;
  assign wr_acc = (state == WRITE) && s_valid;
  assign rd_iss = (state == READ);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = (n_req == '0) ? DONE : WRITE;
      WRITE:   if (wr_acc && ({1'b0, wr_cnt} == n_last)) state_nx = READ;
      READ:    if ({1'b0, rd_cnt} == n_last) state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // BRAM port drive: port 0 only on a write handshake, port 1 only while reading.
  assign en0    = wr_acc;
  assign we0    = wr_acc;
  assign addr0  = wr_acc ? wr_cnt : '0;
  assign d0     = wr_acc ? s_data : '0;
  assign en1    = rd_iss;
  assign we1    = 1'b0;
  assign addr1  = rd_iss ? rd_cnt : '0;
  assign m_valid = rd_pend;
  assign m_data  = q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_pend <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      n_lat   <= '0;
    end else begin
      state   <= state_nx;
      s_ready <= (state_nx == WRITE);
      busy    <= (state_nx != IDLE);
      done    <= (state_nx == DONE);
      rd_pend <= rd_iss;
      if (state == IDLE && start_i) begin
        n_lat  <= n_req;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (wr_acc) wr_cnt <= wr_cnt + 1'b1;
        if (rd_iss) rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

endmodule
